axi_master_wr_burst: RTL

Parametrised AXI write master. It accepts one write command at a time from a local command port and issues the AW channel, with FIXED, INCR or WRAP bursts of 1..2^LEN_BITS beats. It streams beats from a local data port onto the W channel with strobes, then collects and checks the B response. It sits between test/DMA logic and the AXI interconnect and is the burst-capable successor of the single-beat write master.

---
 rtl/axi_master_wr_burst_if.sv | 69 ++++++
 rtl/axi_master_wr_burst.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/axi_master_wr_burst_if.sv
// Command, local write-data and AXI AW/W/B channels of the burst write master.
// The master modport is the design side; slave is the command source / AXI slave side.
interface axi_master_wr_burst_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int SIZE_BITS = 3,
    parameter int ID_BITS   = 4
);
    logic                   cmd_valid;
    logic                   cmd_ready;
    logic [ADDR_BITS-1:0]   cmd_addr;
    logic [LEN_BITS-1:0]    cmd_len;
    logic [SIZE_BITS-1:0]   cmd_size;
    logic [1:0]             cmd_burst;
    logic [3:0]             cmd_cache;
    logic [ID_BITS-1:0]     cmd_id;

    logic                   wd_valid;
    logic                   wd_ready;
    logic [DATA_BITS-1:0]   wd_data;
    logic [DATA_BITS/8-1:0] wd_strb;

    logic                   aw_valid;
    logic                   aw_ready;
    logic [ID_BITS-1:0]     aw_id;
    logic [ADDR_BITS-1:0]   aw_addr;
    logic [LEN_BITS-1:0]    aw_len;
    logic [SIZE_BITS-1:0]   aw_size;
    logic [1:0]             aw_burst;
    logic [3:0]             aw_cache;

    logic                   w_valid;
    logic                   w_ready;
    logic [DATA_BITS-1:0]   w_data;
    logic [DATA_BITS/8-1:0] w_strb;
    logic                   w_last;

    logic                   b_valid;
    logic                   b_ready;
    logic [ID_BITS-1:0]     b_id;
    logic [1:0]             b_resp;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_cache, cmd_id,
        output cmd_ready,
        input  wd_valid, wd_data, wd_strb,
        output wd_ready,
        output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id, b_resp,
        output b_ready
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_cache, cmd_id,
        input  cmd_ready,
        output wd_valid, wd_data, wd_strb,
        input  wd_ready,
        input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_cache,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id, b_resp,
        input  b_ready
    );
endinterface

// File: rtl/axi_master_wr_burst.sv
// Single-outstanding AXI write master: one command -> AW + FIXED/INCR/WRAP W burst -> B check.
// Illegal commands complete without bus traffic and report SLVERR with done_err[0].
module axi_master_wr_burst #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int LEN_BITS  = 8,
    parameter int SIZE_BITS = 3,
    parameter int ID_BITS   = 4
) (
    input  logic                 aclk,
    input  logic                 areset_n,
    axi_master_wr_burst_if.master bus,
    output logic [ADDR_BITS-1:0] beat_addr,
    output logic                 busy,
    output logic                 done,
    output logic [1:0]           done_resp,
    output logic [1:0]           done_err
);
    localparam int STRB_BITS = DATA_BITS / 8;
    localparam int SIZE_MAX  = $clog2(STRB_BITS);

    typedef enum logic [2:0] {IDLE, CHECK, XFER, RESP, DONE} state_t;

    state_t                 state_q;
    logic                   cmd_ready_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [LEN_BITS-1:0]    len_q;
    logic [SIZE_BITS-1:0]   size_q;
    logic [1:0]             burst_q;
    logic [3:0]             cache_q;
    logic [ID_BITS-1:0]     id_q;
    logic                   aw_valid_q, aw_done_q;
    logic                   w_valid_q, w_last_q, w_done_q;
    logic [DATA_BITS-1:0]   w_data_q;
    logic [STRB_BITS-1:0]   w_strb_q;
    logic [LEN_BITS-1:0]    ld_cnt_q;
    logic                   loaded_all_q;
    logic                   b_ready_q;
    logic [ADDR_BITS-1:0]   beat_addr_q;
    logic                   busy_q, done_q;
    logic [1:0]             done_resp_q, done_err_q;

    logic                   aw_hs, w_hs, wd_hs, b_hs, wd_ready;
    logic [63:0]            burst_bytes;
    logic [ADDR_BITS-1:0]   step, wrap_mask, start_addr_d, beat_addr_d;
    logic                   bad_burst, bad_wrap, bad_size, bad_4k, illegal_d;

    // Burst geometry is derived from the registered command only.
    assign burst_bytes  = (64'(len_q) + 64'd1) << size_q;
    assign step         = ADDR_BITS'(1) << size_q;
    assign wrap_mask    = ADDR_BITS'(burst_bytes) - ADDR_BITS'(1);
    assign start_addr_d = addr_q & ~(step - ADDR_BITS'(1));

    always_comb begin
        beat_addr_d = beat_addr_q;
        case (burst_q)
            2'b00:   beat_addr_d = beat_addr_q;
            2'b10:   beat_addr_d = (beat_addr_q & ~wrap_mask) | ((beat_addr_q + step) & wrap_mask);
            default: beat_addr_d = beat_addr_q + step;
        endcase
    end

    assign bad_burst = (burst_q == 2'b11);
    assign bad_wrap  = (burst_q == 2'b10) &&
                       !((len_q == LEN_BITS'(1)) || (len_q == LEN_BITS'(3)) ||
                         (len_q == LEN_BITS'(7)) || (len_q == LEN_BITS'(15)));
    assign bad_size  = 32'(size_q) > 32'(SIZE_MAX);
    assign bad_4k    = (burst_q == 2'b01) && ((64'(addr_q[11:0]) + burst_bytes) > 64'd4096);
    assign illegal_d = bad_burst | bad_wrap | bad_size | bad_4k;

    // One-entry skid: a new beat may load whenever the held beat is empty or leaving.
    assign wd_ready = (state_q == XFER) && !loaded_all_q && (!w_valid_q || bus.w_ready);
    assign aw_hs    = aw_valid_q && bus.aw_ready;
    assign w_hs     = w_valid_q && bus.w_ready;
    assign wd_hs    = bus.wd_valid && wd_ready;
    assign b_hs     = b_ready_q && bus.b_valid;

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state_q      <= IDLE;
            cmd_ready_q  <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            size_q       <= '0;
            burst_q      <= '0;
            cache_q      <= '0;
            id_q         <= '0;
            aw_valid_q   <= 1'b0;
            aw_done_q    <= 1'b0;
            w_valid_q    <= 1'b0;
            w_last_q     <= 1'b0;
            w_done_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            ld_cnt_q     <= '0;
            loaded_all_q <= 1'b0;
            b_ready_q    <= 1'b0;
            beat_addr_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_resp_q  <= '0;
            done_err_q   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (bus.cmd_valid && cmd_ready_q) begin
                        addr_q      <= bus.cmd_addr;
                        len_q       <= bus.cmd_len;
                        size_q      <= bus.cmd_size;
                        burst_q     <= bus.cmd_burst;
                        cache_q     <= bus.cmd_cache;
                        id_q        <= bus.cmd_id;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CHECK;
                    end
                end
                CHECK: begin
                    if (illegal_d) begin
                        done_resp_q <= 2'b10;
                        done_err_q  <= 2'b01;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        aw_valid_q   <= 1'b1;
                        aw_done_q    <= 1'b0;
                        w_done_q     <= 1'b0;
                        ld_cnt_q     <= '0;
                        loaded_all_q <= 1'b0;
                        beat_addr_q  <= start_addr_d;
                        state_q      <= XFER;
                    end
                end
                XFER: begin
                    if (aw_hs) begin
                        aw_valid_q <= 1'b0;
                        aw_done_q  <= 1'b1;
                    end
                    if (w_hs) begin
                        beat_addr_q <= beat_addr_d;
                        if (w_last_q) w_done_q <= 1'b1;
                    end
                    if (wd_hs) begin
                        w_valid_q <= 1'b1;
                        w_data_q  <= bus.wd_data;
                        w_strb_q  <= bus.wd_strb;
                        w_last_q  <= (ld_cnt_q == len_q);
                        ld_cnt_q  <= ld_cnt_q + LEN_BITS'(1);
                        if (ld_cnt_q == len_q) loaded_all_q <= 1'b1;
                    end else if (w_hs) begin
                        w_valid_q <= 1'b0;
                    end
                    // B is only accepted once both the address and the final beat are out.
                    if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && w_last_q))) begin
                        b_ready_q <= 1'b1;
                        state_q   <= RESP;
                    end
                end
                RESP: begin
                    if (b_hs) begin
                        done_resp_q <= bus.b_resp;
                        done_err_q  <= {bus.b_id != id_q, 1'b0};
                        b_ready_q   <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wd_ready  = wd_ready;
    assign bus.aw_valid  = aw_valid_q;
    assign bus.aw_id     = id_q;
    assign bus.aw_addr   = addr_q;
    assign bus.aw_len    = len_q;
    assign bus.aw_size   = size_q;
    assign bus.aw_burst  = burst_q;
    assign bus.aw_cache  = cache_q;
    assign bus.w_valid   = w_valid_q;
    assign bus.w_data    = w_data_q;
    assign bus.w_strb    = w_strb_q;
    assign bus.w_last    = w_last_q;
    assign bus.b_ready   = b_ready_q;
    assign beat_addr     = beat_addr_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign done_resp     = done_resp_q;
    assign done_err      = done_err_q;
endmodule
